// File: rtl/mem_ctrl_pkg.sv
// Shared types for mem_ctrl: FSM states, ls_size encodings, owner and size helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MemByte = 2'd0;
  localparam logic [1:0] MemHalf = 2'd1;
  localparam logic [1:0] MemWord = 2'd2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Byte count for an ls_size code; the reserved code 3 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      MemByte: size_to_n = 3'd1;
      MemHalf: size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_fetch_buf.sv
// One-entry fetch buffer: tag compare, word storage, store-overlap invalidate.
module mem_ctrl_fetch_buf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lk_addr,
  output logic        o_hit,
  output logic [31:0] o_word,
  input  logic        i_fill,
  input  logic [31:0] i_fill_addr,
  input  logic [31:0] i_fill_word,
  input  logic        i_inv,
  input  logic [31:0] i_st_addr,
  input  logic [2:0]  i_st_n
);

  logic        r_valid;
  logic [31:0] r_tag;
  logic [31:0] r_word;
  logic        w_overlap;

  // Modular distance test so ranges straddling the 2^32 wrap are caught too.
  assign w_overlap = ((i_st_addr - r_tag) < 32'd4) ||
                     ((r_tag - i_st_addr) < {29'd0, i_st_n});
  assign o_hit  = r_valid && (r_tag == i_lk_addr);
  assign o_word = r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_word  <= '0;
    end else if (i_inv && w_overlap) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_addr;
      r_word  <= i_fill_word;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF fetches against MEM load/store.
// Optional one-entry fetch buffer compiled in with MEMCTRL_FETCH_BUF_EN.
import mem_ctrl_pkg::*;

module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        busy
);

  state_e      r_state, w_state_nxt;
  owner_e      r_owner, w_owner_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [2:0]  r_n, w_n_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_replay, w_replay_nxt;
  logic [31:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]  r_mem_dout, w_mem_dout_nxt;
  logic        r_mem_wr, w_mem_wr_nxt;
  logic        r_if_done, w_if_done_nxt;
  logic        r_ls_done, w_ls_done_nxt;
  logic [31:0] r_if_inst, w_if_inst_nxt;
  logic [31:0] r_ls_rdata, w_ls_rdata_nxt;
  logic [1:0]  w_lane;
  logic [31:0] w_cap;
  logic        w_fb_hit;
  logic [31:0] w_fb_word;

`ifdef MEMCTRL_FETCH_BUF_EN
  logic w_fill, w_inv;

  // r_mem_a has already run one past the last byte when a read completes.
  assign w_fill = (r_state == ST_READ) && rdy_in && !r_replay &&
                  (r_idx == r_n) && (r_owner == OWN_IF);
  assign w_inv  = (r_state == ST_IDLE) && rdy_in && ls_req && ls_we;

  mem_ctrl_fetch_buf u_fetch_buf (
    .i_clk       (clk_in),
    .i_rst_n     (rst_in),
    .i_lk_addr   (if_addr),
    .o_hit       (w_fb_hit),
    .o_word      (w_fb_word),
    .i_fill      (w_fill),
    .i_fill_addr (r_mem_a - 32'd4),
    .i_fill_word (w_cap),
    .i_inv       (w_inv),
    .i_st_addr   (ls_addr),
    .i_st_n      (size_to_n(ls_size))
  );
`else
  assign w_fb_hit  = 1'b0;
  assign w_fb_word = '0;
`endif

  // Replay cycle re-drives the previous byte so its data is fresh on mem_din.
  assign mem_a    = (r_replay && rdy_in) ? (r_mem_a - 32'd1) : r_mem_a;
  assign mem_wr   = r_mem_wr & rdy_in;
  assign mem_dout = r_mem_dout;
  assign if_done  = r_if_done;
  assign ls_done  = r_ls_done;
  assign if_inst  = r_if_inst;
  assign ls_rdata = r_ls_rdata;
  assign busy     = (r_state != ST_IDLE);

  always_comb begin
    w_lane = r_idx[1:0] - 2'd1;
    w_cap  = r_data;
    w_cap[{w_lane, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_idx_nxt      = r_idx;
    w_n_nxt        = r_n;
    w_wdata_nxt    = r_wdata;
    w_data_nxt     = r_data;
    w_replay_nxt   = r_replay;
    w_mem_a_nxt    = r_mem_a;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = r_mem_wr;
    w_if_done_nxt  = r_if_done;
    w_ls_done_nxt  = r_ls_done;
    w_if_inst_nxt  = r_if_inst;
    w_ls_rdata_nxt = r_ls_rdata;
    if (!rdy_in) begin
      if (r_state == ST_READ && r_idx != 3'd0) w_replay_nxt = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_if_done_nxt = 1'b0;
          w_ls_done_nxt = 1'b0;
          if (ls_req) begin
            w_owner_nxt = OWN_LS;
            w_n_nxt     = size_to_n(ls_size);
            w_idx_nxt   = 3'd0;
            w_mem_a_nxt = ls_addr;
            w_data_nxt  = '0;
            if (ls_we) begin
              w_state_nxt    = ST_WRITE;
              w_mem_wr_nxt   = 1'b1;
              w_mem_dout_nxt = ls_wdata[7:0];
              w_wdata_nxt    = ls_wdata >> 8;
            end else begin
              w_state_nxt = ST_READ;
            end
          end else if (if_req) begin
            w_owner_nxt = OWN_IF;
            w_n_nxt     = 3'd4;
            w_idx_nxt   = 3'd0;
            w_mem_a_nxt = if_addr;
            w_data_nxt  = '0;
            if (w_fb_hit) begin
              w_state_nxt   = ST_DONE;
              w_if_done_nxt = 1'b1;
              w_if_inst_nxt = w_fb_word;
            end else begin
              w_state_nxt = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_replay) begin
            w_replay_nxt = 1'b0;
          end else begin
            if (r_idx != 3'd0) w_data_nxt = w_cap;
            if (r_idx == r_n) begin
              w_state_nxt = ST_DONE;
              if (r_owner == OWN_IF) begin
                w_if_done_nxt = 1'b1;
                w_if_inst_nxt = w_cap;
              end else begin
                w_ls_done_nxt  = 1'b1;
                w_ls_rdata_nxt = w_cap;
              end
            end else begin
              w_idx_nxt   = r_idx + 3'd1;
              w_mem_a_nxt = r_mem_a + 32'd1;
            end
          end
        end
        ST_WRITE: begin
          if (r_idx == r_n - 3'd1) begin
            w_state_nxt   = ST_DONE;
            w_mem_wr_nxt  = 1'b0;
            w_ls_done_nxt = 1'b1;
          end else begin
            w_idx_nxt      = r_idx + 3'd1;
            w_mem_a_nxt    = r_mem_a + 32'd1;
            w_mem_dout_nxt = r_wdata[7:0];
            w_wdata_nxt    = r_wdata >> 8;
          end
        end
        ST_DONE: begin
          w_state_nxt   = ST_IDLE;
          w_if_done_nxt = 1'b0;
          w_ls_done_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_idx      <= '0;
      r_n        <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_replay   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_inst  <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_idx      <= w_idx_nxt;
      r_n        <= w_n_nxt;
      r_wdata    <= w_wdata_nxt;
      r_data     <= w_data_nxt;
      r_replay   <= w_replay_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_if_done  <= w_if_done_nxt;
      r_ls_done  <= w_ls_done_nxt;
      r_if_inst  <= w_if_inst_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
    end
  end

endmodule
